// File: rtl/out_port_unit_if.sv
// rtl/out_port_unit_if.sv - processor-side and device-side signal bundle for the output port unit
//
// Signals:
//   A, B, V, X  processor register values, selectable as the output byte
//   iput        output-instruction strobe, held while a write is requested
//   src_sel     source select: 0=A, 1=B, 2=V, 3=X
//   flush       synchronous FIFO clear
//   stall       processor hold request (iput while the FIFO is full)
//   OUT         last byte accepted into the FIFO
//   out_data    FIFO head byte to the external device
//   out_valid   out_data is valid
//   out_ready   device accepts the head byte
//   level       current FIFO occupancy
//   sent        count of bytes handed to the device, mod 256
// Modports: master = processor/device side, slave = the port unit.
interface out_port_unit_if #(
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  A;
    logic [7:0]  B;
    logic [7:0]  V;
    logic [7:0]  X;
    logic        iput;
    logic [1:0]  src_sel;
    logic        flush;
    logic        stall;
    logic [7:0]  OUT;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [AW:0] level;
    logic [7:0]  sent;

    modport master (
        output A, B, V, X, iput, src_sel, flush, out_ready,
        input  stall, OUT, out_data, out_valid, level, sent
    );

    modport slave (
        input  A, B, V, X, iput, src_sel, flush, out_ready,
        output stall, OUT, out_data, out_valid, level, sent
    );
endinterface

// File: rtl/out_port_unit.sv
// rtl/out_port_unit.sv - processor output port with a DEPTH-entry byte FIFO toward an external device
//
// Ports:
//   ck     the only clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    out_port_unit_if.slave: processor push side (A/B/V/X, iput, src_sel,
//          flush, stall, OUT), device pop side (out_data, out_valid, out_ready),
//          status (level, sent)
// DEPTH must be a power of two, at least 2.
module out_port_unit #(
    parameter int DEPTH = 4
) (
    input  logic          ck,
    input  logic          rst_n,
    out_port_unit_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];
    logic [7:0]  out_reg;
    logic [7:0]  sent_cnt;
    logic [7:0]  src;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;

    always_comb begin
        src = bus.A;
        case (bus.src_sel)
            2'd0:    src = bus.A;
            2'd1:    src = bus.B;
            2'd2:    src = bus.V;
            default: src = bus.X;
        endcase
    end

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    // No bypass: a full FIFO blocks the push even if a pop frees a slot this edge.
    assign push = bus.iput & ~full & ~bus.flush;
    assign pop  = ~empty & bus.out_ready & ~bus.flush;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            out_reg  <= 8'h00;
            sent_cnt <= 8'h00;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                out_reg <= src;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                sent_cnt <= sent_cnt + 8'd1;
            end
        end
    end

    // Storage is not reset; out_data only matters while out_valid is high.
    always_ff @(posedge ck) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= src;
        end
    end

    // Pointers clear asynchronously, so stall is already 0 while reset is held.
    assign bus.stall     = bus.iput & full;
    assign bus.out_valid = ~empty;
    assign bus.out_data  = mem[rd_ptr[AW-1:0]];
    assign bus.OUT       = out_reg;
    assign bus.level     = wr_ptr - rd_ptr;
    assign bus.sent      = sent_cnt;
endmodule

// File: tb/tb_out_port_unit.sv
// tb/tb_out_port_unit.sv - directed self-checking bench for out_port_unit
module tb_out_port_unit;
    localparam int DEPTH = 4;

    logic ck;
    logic rst_n;
    int   ncmp;
    int   nerr;

    out_port_unit_if #(.DEPTH(DEPTH)) bus ();

    out_port_unit #(.DEPTH(DEPTH)) dut (
        .ck    (ck),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    initial begin
        ncmp = 0;
        nerr = 0;
        rst_n = 1'b0;
        bus.A = 8'h00; bus.B = 8'h00; bus.V = 8'h00; bus.X = 8'h00;
        bus.iput = 1'b0; bus.src_sel = 2'd0; bus.flush = 1'b0; bus.out_ready = 1'b0;

        // Reset state; stall stays low under reset even with iput high
        #12;
        bus.iput = 1'b1;
        #1;
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_OUT", 32'(bus.OUT), 8'h00);
        chk("rst_sent", 32'(bus.sent), 8'h00);
        chk("rst_stall", 32'(bus.stall), 0);
        bus.iput = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();

        // Single byte: one-cycle latency, then popped
        bus.A = 8'h3C; bus.src_sel = 2'd0; bus.iput = 1'b1; bus.out_ready = 1'b1;
        #1;
        chk("lat_valid_before", 32'(bus.out_valid), 0);
        tick();
        bus.iput = 1'b0;
        chk("one_valid", 32'(bus.out_valid), 1);
        chk("one_data", 32'(bus.out_data), 8'h3C);
        chk("one_OUT", 32'(bus.OUT), 8'h3C);
        tick();
        chk("one_sent", 32'(bus.sent), 1);
        chk("one_valid_after", 32'(bus.out_valid), 0);

        // Fill to full from all four sources
        bus.out_ready = 1'b0;
        bus.B = 8'h01; bus.V = 8'h02; bus.X = 8'h03; bus.A = 8'h04;
        bus.iput = 1'b1;
        bus.src_sel = 2'd1; tick();
        bus.src_sel = 2'd2; tick();
        bus.src_sel = 2'd3; tick();
        bus.src_sel = 2'd0; tick();
        bus.iput = 1'b0;
        #1;
        chk("full_level", 32'(bus.level), 4);
        chk("full_stall_idle", 32'(bus.stall), 0);
        chk("full_OUT", 32'(bus.OUT), 8'h04);
        chk("full_head", 32'(bus.out_data), 8'h01);

        // Fifth write stalls and is held
        bus.B = 8'h05; bus.src_sel = 2'd1; bus.iput = 1'b1;
        #1;
        chk("fifth_stall", 32'(bus.stall), 1);
        tick();
        chk("fifth_OUT_hold", 32'(bus.OUT), 8'h04);
        chk("fifth_level", 32'(bus.level), 4);

        // Full with simultaneous pop: no bypass, push lands the edge after
        bus.out_ready = 1'b1;
        #1;
        chk("nobypass_stall", 32'(bus.stall), 1);
        tick();
        chk("pop1_level", 32'(bus.level), 3);
        chk("pop1_sent", 32'(bus.sent), 2);
        chk("pop1_head", 32'(bus.out_data), 8'h02);
        chk("pop1_stall", 32'(bus.stall), 0);
        tick();
        bus.iput = 1'b0;
        chk("push5_OUT", 32'(bus.OUT), 8'h05);
        chk("push5_level", 32'(bus.level), 3);
        chk("push5_head", 32'(bus.out_data), 8'h03);
        tick();
        chk("drain_head04", 32'(bus.out_data), 8'h04);
        tick();
        chk("drain_head05", 32'(bus.out_data), 8'h05);
        tick();
        chk("drain_sent", 32'(bus.sent), 6);
        chk("drain_valid", 32'(bus.out_valid), 0);

        // Level 2, ten simultaneous push/pop edges across the index wrap
        bus.out_ready = 1'b0;
        bus.src_sel = 2'd3; bus.iput = 1'b1;
        bus.X = 8'h10; tick();
        bus.X = 8'h11; tick();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.X = 8'(8'h12 + i);
            #1;
            chk("stream_head", 32'(bus.out_data), 32'(8'h10 + i));
            chk("stream_level", 32'(bus.level), 2);
            tick();
        end
        bus.iput = 1'b0; bus.out_ready = 1'b0;
        chk("stream_level_end", 32'(bus.level), 2);
        chk("stream_sent", 32'(bus.sent), 16);
        chk("stream_head_end", 32'(bus.out_data), 8'h1A);

        // Level 3, flush wins over a push
        bus.X = 8'h30; bus.iput = 1'b1; tick();
        bus.X = 8'h77; bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0; bus.iput = 1'b0;
        chk("flush_level", 32'(bus.level), 0);
        chk("flush_valid", 32'(bus.out_valid), 0);
        chk("flush_OUT", 32'(bus.OUT), 8'h30);
        chk("flush_sent", 32'(bus.sent), 16);

        // out_ready with nothing queued changes nothing
        bus.out_ready = 1'b1;
        tick();
        chk("idle_ready_sent", 32'(bus.sent), 16);
        chk("idle_ready_level", 32'(bus.level), 0);

        // Stream until sent reaches FF, then one pop wraps it
        bus.X = 8'h55; bus.iput = 1'b1;
        repeat (240) tick();
        chk("sent_ff", 32'(bus.sent), 8'hFF);
        chk("sent_ff_level", 32'(bus.level), 1);
        bus.iput = 1'b0;
        tick();
        chk("sent_wrap", 32'(bus.sent), 8'h00);

        // Mid-stream asynchronous reset at level 3
        bus.out_ready = 1'b0; bus.iput = 1'b1;
        repeat (4) tick();
        bus.iput = 1'b0; bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("pre_rst_level", 32'(bus.level), 3);
        chk("pre_rst_sent", 32'(bus.sent), 1);
        #2;
        bus.iput = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("async_level", 32'(bus.level), 0);
        chk("async_valid", 32'(bus.out_valid), 0);
        chk("async_sent", 32'(bus.sent), 0);
        chk("async_OUT", 32'(bus.OUT), 8'h00);
        chk("async_stall", 32'(bus.stall), 0);
        bus.iput = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();

        // First push after reset behaves as into an empty FIFO
        bus.A = 8'h99; bus.src_sel = 2'd0; bus.iput = 1'b1;
        tick();
        bus.iput = 1'b0;
        chk("post_rst_valid", 32'(bus.out_valid), 1);
        chk("post_rst_data", 32'(bus.out_data), 8'h99);
        chk("post_rst_level", 32'(bus.level), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
